qsync_rmw: RTL and testbench

- Second-generation QBUS-to-synchronous slave interface for the QSIC FPGA. It sits between the QBUS driver circuitry and the internal I/O register bus.
- Carries everything the first interface did, plus:
  - byte writes (DATOB)
  - read-modify-write cycles (DATIO/DATIOB)
  - devices that need several clocks to produce read data
  - a read-timeout abort
- All protocol sequencing is a single clk-domain state machine. Only the address and write-data capture latches are clocked by bus strobes.

---
 rtl/qsync_rmw.sv | 169 ++++++++++++++++
 tb/tb_qsync_rmw.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qsync_rmw.sv
// QBUS-to-synchronous slave interface: word/byte writes, read-modify-write,
// variable-latency reads with timeout abort. All sequencing runs in the clk domain.
module qsync_rmw #(
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RD_TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              DALtx,
  inout  wire  [21:0]       DAL,
  input  logic              RBS7,
  input  logic              RWTBT,
  input  logic              RSYNC,
  input  logic              RDIN,
  input  logic              RDOUT,
  output logic              TRPLY,
  output logic [ADDR_W-1:0] iADDR,
  output logic              iBS7,
  input  logic              iREAD_MATCH,
  input  logic              iWRITE_MATCH,
  output logic              iREAD,
  input  logic              iRVALID,
  input  logic [15:0]       iRDATA,
  output logic              iWRITE,
  output logic [15:0]       iWDATA,
  output logic [1:0]        iWBE,
  output logic              busy,
  output logic              rd_timeout
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_WAIT, S_RREQ, S_RDRV, S_RRPLY, S_WR, S_WRPLY, S_HOLD
  } state_t;

  localparam logic [7:0] TO_MAX = 8'(RD_TIMEOUT);

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      a_addr;
  logic                   a_bs7, a_wtbt;
  logic [15:0]            d_data;
  logic                   d_wtbt;
  logic [SYNC_STAGES-1:0] sync_sh, din_sh, dout_sh;
  logic                   s_sync, s_din, s_dout;
  logic [7:0]             cnt;
  logic [15:0]            rd_reg;
  logic                   unused_bits;

  assign unused_bits = ^{DAL, a_wtbt};

  // Address/data capture, clocked directly by the bus strobes.
  always_ff @(posedge RSYNC or negedge reset_n) begin
    if (!reset_n) begin
      a_addr <= '0;
      a_bs7  <= 1'b0;
      a_wtbt <= 1'b0;
    end else begin
      a_addr <= DAL[ADDR_W-1:0];
      a_bs7  <= RBS7;
      a_wtbt <= RWTBT;
    end
  end

  always_ff @(posedge RDOUT or negedge reset_n) begin
    if (!reset_n) begin
      d_data <= '0;
      d_wtbt <= 1'b0;
    end else begin
      d_data <= DAL[15:0];
      d_wtbt <= RWTBT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_sh <= '0;
      din_sh  <= '0;
      dout_sh <= '0;
    end else begin
      sync_sh <= {sync_sh[SYNC_STAGES-2:0], RSYNC};
      din_sh  <= {din_sh[SYNC_STAGES-2:0], RDIN};
      dout_sh <= {dout_sh[SYNC_STAGES-2:0], RDOUT};
    end
  end

  assign s_sync = sync_sh[SYNC_STAGES-1];
  assign s_din  = din_sh[SYNC_STAGES-1];
  assign s_dout = dout_sh[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && !s_sync) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (s_sync) state_d = S_ADDR;
        S_ADDR:  state_d = S_WAIT;
        S_WAIT: begin
          if (s_din && iREAD_MATCH)        state_d = S_RREQ;
          else if (s_dout && iWRITE_MATCH) state_d = S_WR;
        end
        S_RREQ: begin
          if (iRVALID)            state_d = S_RDRV;
          else if (cnt == TO_MAX) state_d = S_HOLD;
        end
        S_RDRV:  state_d = S_RRPLY;
        S_RRPLY: if (!s_din) state_d = S_WAIT;
        S_WR:    state_d = S_WRPLY;
        S_WRPLY: if (!s_dout) state_d = S_WAIT;
        S_HOLD:  state_d = S_HOLD;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Write data is loaded on entry to WR so it is valid alongside the iWRITE strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iADDR  <= '0;
      iBS7   <= 1'b0;
      iWDATA <= '0;
      rd_reg <= '0;
      cnt    <= '0;
    end else begin
      if (state_q == S_ADDR) begin
        iADDR <= a_addr;
        iBS7  <= a_bs7;
      end
      if (state_q == S_WAIT && state_d == S_WR) iWDATA <= d_data;
      if (state_q == S_RREQ && iRVALID)         rd_reg <= iRDATA;
      cnt <= (state_q == S_RREQ) ? cnt + 8'd1 : '0;
    end
  end

  always_comb begin
    DALtx      = 1'b0;
    TRPLY      = 1'b0;
    iREAD      = 1'b0;
    iWRITE     = 1'b0;
    iWBE       = 2'b00;
    rd_timeout = 1'b0;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_RREQ: begin
        iREAD      = (cnt == 8'd0);
        rd_timeout = (cnt == TO_MAX) && !iRVALID;
      end
      S_RDRV:  DALtx = 1'b1;
      S_RRPLY: begin
        DALtx = 1'b1;
        TRPLY = 1'b1;
      end
      S_WR: begin
        iWRITE = 1'b1;
        iWBE   = !d_wtbt ? 2'b11 : (a_addr[0] ? 2'b10 : 2'b01);
      end
      S_WRPLY: TRPLY = 1'b1;
      default: ;
    endcase
  end

  assign DAL = DALtx ? {6'b0, rd_reg} : 'z;

endmodule

// File: tb/tb_qsync_rmw.sv
// Directed bench for qsync_rmw: a QBUS master model drives bus cycles, a device
// model answers register reads, and negedge monitors record strobes and replies.
module tb_qsync_rmw;

  localparam int SS = 2;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        RBS7 = 1'b0, RWTBT = 1'b0, RSYNC = 1'b0, RDIN = 1'b0, RDOUT = 1'b0;
  logic        iREAD_MATCH = 1'b1, iWRITE_MATCH = 1'b1;
  logic        iRVALID;
  logic [15:0] iRDATA;
  logic        DALtx, TRPLY, iBS7, iREAD, iWRITE, busy, rd_timeout;
  logic [12:0] iADDR;
  logic [15:0] iWDATA;
  logic [1:0]  iWBE;
  wire  [21:0] DAL;
  logic [21:0] tb_dal = '0;
  logic        tb_dal_en = 1'b0;

  assign DAL = tb_dal_en ? tb_dal : 'z;

  qsync_rmw #(.ADDR_W(13), .SYNC_STAGES(SS), .RD_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .DALtx(DALtx), .DAL(DAL),
    .RBS7(RBS7), .RWTBT(RWTBT), .RSYNC(RSYNC), .RDIN(RDIN), .RDOUT(RDOUT),
    .TRPLY(TRPLY), .iADDR(iADDR), .iBS7(iBS7),
    .iREAD_MATCH(iREAD_MATCH), .iWRITE_MATCH(iWRITE_MATCH),
    .iREAD(iREAD), .iRVALID(iRVALID), .iRDATA(iRDATA),
    .iWRITE(iWRITE), .iWDATA(iWDATA), .iWBE(iWBE),
    .busy(busy), .rd_timeout(rd_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Device: delay 0 answers in the iREAD cycle, N>0 answers N clks later, <0 never.
  int          dev_delay = 0;
  logic [15:0] dev_data = '0;
  int          dly_cnt = 0;
  always @(posedge clk) begin
    if (iREAD) dly_cnt <= 1;
    else if (dly_cnt != 0 && dly_cnt < 1000) dly_cnt <= dly_cnt + 1;
  end
  assign iRVALID = (dev_delay == 0) ? iREAD : (dev_delay > 0 && dly_cnt == dev_delay);
  assign iRDATA  = dev_data;

  int n_rd = 0, n_wr = 0, n_to = 0, n_rply = 0, n_dal = 0;
  int t_rd = 0, t_to = 0, t_rply = 0, t_dal = 0, t_fall = 0;
  logic [21:0] dal_seen = '0;
  logic [15:0] wdata_seen = '0;
  logic [1:0]  wbe_seen = '0;
  logic trply_prev = 1'b0, daltx_prev = 1'b0;

  always @(negedge clk) begin
    if (iREAD) begin n_rd++; t_rd = cyc; end
    if (iWRITE) begin n_wr++; wdata_seen = iWDATA; wbe_seen = iWBE; end
    if (rd_timeout) begin n_to++; t_to = cyc; end
    if (TRPLY && !trply_prev) begin n_rply++; t_rply = cyc; end
    if (!TRPLY && trply_prev) t_fall = cyc;
    if (DALtx && !daltx_prev) begin n_dal++; t_dal = cyc; dal_seen = DAL; end
    trply_prev = TRPLY;
    daltx_prev = DALtx;
  end

  int n_cmp = 0, n_err = 0;
  int b_rd, b_wr, b_to, b_rply, b_dal;
  int neg_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_rd = n_rd; b_wr = n_wr; b_to = n_to; b_rply = n_rply; b_dal = n_dal;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_trply(input logic val, input string tag);
    for (int i = 0; i < 64 && TRPLY !== val; i++) tick(1);
    check(tag, 32'(TRPLY), 32'(val));
  endtask

  task automatic start_cycle(input logic [21:0] addr, input logic bs7);
    tb_dal = addr; tb_dal_en = 1'b1; RBS7 = bs7; RWTBT = 1'b0;
    tick(1);
    RSYNC = 1'b1;
    tick(1);
    tb_dal_en = 1'b0; RBS7 = 1'b0;
  endtask

  task automatic end_cycle(input string tag);
    RSYNC = 1'b0;
    for (int i = 0; i < 64 && busy !== 1'b0; i++) tick(1);
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic do_read();
    RDIN = 1'b1;
    wait_trply(1'b1, "rd_reply");
    tick(1);
    RDIN = 1'b0;
    neg_cyc = cyc;
    wait_trply(1'b0, "rd_release");
  endtask

  task automatic do_write(input logic [15:0] data, input logic wtbt);
    tb_dal = {6'b0, data}; tb_dal_en = 1'b1; RWTBT = wtbt;
    tick(1);
    RDOUT = 1'b1;
    wait_trply(1'b1, "wr_reply");
    tick(1);
    RDOUT = 1'b0;
    wait_trply(1'b0, "wr_release");
    tb_dal_en = 1'b0; RWTBT = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick(3);
    check("rst_trply", 32'(TRPLY), 32'd0);
    check("rst_daltx", 32'(DALtx), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_wbe",   32'(iWBE), 32'd0);
    check("rst_addr",  32'(iADDR), 32'd0);
    check("rst_strb",  32'({iREAD, iWRITE, rd_timeout, iBS7}), 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Word read of 017772 on the I/O page, device answers immediately
    dev_delay = 0; dev_data = 16'hA5C3; snap();
    start_cycle(22'o017772, 1'b1);
    do_read();
    end_cycle("rd_idle");
    check("rd_iaddr",  32'(iADDR), 32'h1FFA);
    check("rd_ibs7",   32'(iBS7), 32'd1);
    check("rd_nread",  n_rd - b_rd, 32'd1);
    check("rd_nrply",  n_rply - b_rply, 32'd1);
    check("rd_dal",    32'(dal_seen), 32'h00A5C3);
    check("rd_setup",  32'((t_rply - t_dal) >= 1), 32'd1);
    check("rd_drop",   32'((t_fall - neg_cyc) <= SS + 1), 32'd1);
    check("rd_nto",    n_to - b_to, 32'd0);
    check("rd_daltx",  32'(DALtx), 32'd0);

    // Slow device: data 10 clks after iREAD
    dev_delay = 10; dev_data = 16'h0BEE; snap();
    start_cycle(22'o017774, 1'b1);
    do_read();
    end_cycle("slow_idle");
    check("slow_dal",  32'(dal_seen), 32'h000BEE);
    check("slow_nrd",  n_rd - b_rd, 32'd1);
    check("slow_nto",  n_to - b_to, 32'd0);

    // Device never answers: timeout, no reply, hold until RSYNC drops
    dev_delay = -1; snap();
    start_cycle(22'o017776, 1'b1);
    RDIN = 1'b1;
    for (int i = 0; i < 64 && n_to == b_to; i++) tick(1);
    tick(3);
    check("to_npulse", n_to - b_to, 32'd1);
    check("to_delay",  t_to - t_rd, 32'(TO));
    check("to_nrply",  n_rply - b_rply, 32'd0);
    check("to_ndal",   n_dal - b_dal, 32'd0);
    check("to_hold",   32'(busy), 32'd1);
    RDIN = 1'b0;
    tick(4);
    check("to_hold2",  32'(busy), 32'd1);
    end_cycle("to_idle");
    dev_delay = 0;

    // DATOB to odd address
    snap();
    start_cycle(22'o017773, 1'b1);
    do_write(16'h5A00, 1'b1);
    end_cycle("bo_idle");
    check("bo_nwr",   n_wr - b_wr, 32'd1);
    check("bo_wbe",   32'(wbe_seen), 32'h2);
    check("bo_wdata", 32'(wdata_seen), 32'h5A00);
    check("bo_idle_wbe", 32'(iWBE), 32'd0);

    // DATOB to even address
    snap();
    start_cycle(22'o017772, 1'b1);
    do_write(16'h00C6, 1'b1);
    end_cycle("be_idle");
    check("be_wbe",   32'(wbe_seen), 32'h1);
    check("be_wdata", 32'(wdata_seen), 32'h00C6);

    // Word DATO
    snap();
    start_cycle(22'o017772, 1'b1);
    do_write(16'hBEEF, 1'b0);
    end_cycle("wo_idle");
    check("wo_wbe",   32'(wbe_seen), 32'h3);
    check("wo_wdata", 32'(wdata_seen), 32'hBEEF);
    check("wo_nwr",   n_wr - b_wr, 32'd1);

    // DATIO: read 1234, write back 1235 in one RSYNC
    dev_data = 16'h1234; snap();
    start_cycle(22'o017770, 1'b1);
    do_read();
    do_write(16'h1235, 1'b0);
    end_cycle("rmw_idle");
    check("rmw_nrd",   n_rd - b_rd, 32'd1);
    check("rmw_nwr",   n_wr - b_wr, 32'd1);
    check("rmw_dal",   32'(dal_seen), 32'h001234);
    check("rmw_wdata", 32'(wdata_seen), 32'h1235);
    check("rmw_wbe",   32'(wbe_seen), 32'h3);
    check("rmw_nrply", n_rply - b_rply, 32'd2);
    check("rmw_iaddr", 32'(iADDR), 32'h1FF8);

    // No device claims the address
    iREAD_MATCH = 1'b0; iWRITE_MATCH = 1'b0; snap();
    start_cycle(22'o017766, 1'b1);
    RDIN = 1'b1;
    tick(10);
    check("nm_busy", 32'(busy), 32'd1);
    RDIN = 1'b0;
    tb_dal = 22'h00FFFF; tb_dal_en = 1'b1;
    tick(1);
    RDOUT = 1'b1;
    tick(10);
    RDOUT = 1'b0;
    tick(1);
    tb_dal_en = 1'b0;
    end_cycle("nm_idle");
    check("nm_nrply", n_rply - b_rply, 32'd0);
    check("nm_ndal",  n_dal - b_dal, 32'd0);
    check("nm_nrd",   n_rd - b_rd, 32'd0);
    check("nm_nwr",   n_wr - b_wr, 32'd0);
    iREAD_MATCH = 1'b1; iWRITE_MATCH = 1'b1;

    // Reset while replying to a read: outputs release with no clock edge
    dev_data = 16'h4321;
    start_cycle(22'o017760, 1'b1);
    RDIN = 1'b1;
    wait_trply(1'b1, "rst_mid_reply");
    #2;
    reset_n = 1'b0;
    #1;
    check("rstm_trply", 32'(TRPLY), 32'd0);
    check("rstm_daltx", 32'(DALtx), 32'd0);
    check("rstm_busy",  32'(busy), 32'd0);
    RDIN = 1'b0; RSYNC = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(2);

    dev_data = 16'h7E81; snap();
    start_cycle(22'o017762, 1'b1);
    do_read();
    end_cycle("post_idle");
    check("post_dal",   32'(dal_seen), 32'h007E81);
    check("post_nrply", n_rply - b_rply, 32'd1);
    check("post_iaddr", 32'(iADDR), 32'h1FF2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
